// File: rtl/bounce_emulator.sv
// Emulates a mechanical switch contact: a clean level change on P becomes a
// burst of pseudo-random toggles on Z, followed by a stable settle period.
module bounce_emulator #(
    parameter int          BOUNCE_CYCLES = 2048,
    parameter int          HOLD_MIN      = 16,
    parameter int          SETTLE_CYCLES = 64,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       P,
    output logic       Z,
    output logic       busy,
    output logic [7:0] toggles
);

    typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

    localparam logic [15:0] WIN_LAST = 16'(BOUNCE_CYCLES - 1);
    localparam logic [15:0] SET_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [7:0]  HOLD     = 8'(HOLD_MIN);

    state_t      state, state_n;
    logic [15:0] lfsr;
    logic [15:0] window, window_n;
    logic [15:0] count, count_n;
    logic [7:0]  dwell, dwell_n;
    logic [7:0]  toggles_n;
    logic        target, target_n;
    logic        z_n, busy_n;
    logic        lfsr_fb;
    logic        toggle_ok;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // dwell only needs to reach HOLD, so it saturates there and stays 8 bits wide
    function automatic logic [7:0] dwell_inc(input logic [7:0] v);
        return (v >= HOLD) ? v : v + 8'd1;
    endfunction

    assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign toggle_ok = (dwell >= HOLD) && lfsr[0] && (window < WIN_LAST);

    always_comb begin
        state_n   = state;
        z_n       = Z;
        target_n  = target;
        window_n  = window;
        dwell_n   = dwell;
        count_n   = count;
        toggles_n = toggles;
        case (state)
            IDLE: begin
                if (P != Z) begin
                    z_n       = ~Z;
                    target_n  = P;
                    window_n  = 16'd0;
                    dwell_n   = 8'd0;
                    toggles_n = 8'd1;
                    state_n   = BOUNCE;
                end
            end
            BOUNCE: begin
                window_n = window + 16'd1;
                dwell_n  = dwell_inc(dwell);
                // A level change restarts the window; it outranks the window-end exit.
                if (P != target) begin
                    target_n = P;
                    window_n = 16'd0;
                end else if (window == WIN_LAST) begin
                    z_n     = target;
                    count_n = 16'd0;
                    state_n = SETTLE;
                end
                if (toggle_ok) begin
                    z_n       = ~Z;
                    dwell_n   = 8'd0;
                    toggles_n = sat_inc8(toggles);
                end
            end
            SETTLE: begin
                count_n = count + 16'd1;
                if (P != target) begin
                    z_n       = ~Z;
                    target_n  = P;
                    window_n  = 16'd0;
                    dwell_n   = 8'd0;
                    toggles_n = 8'd1;
                    state_n   = BOUNCE;
                end else if (count == SET_LAST) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            lfsr    <= LFSR_SEED;
            Z       <= 1'b0;
            busy    <= 1'b0;
            toggles <= 8'd0;
            target  <= 1'b0;
            window  <= 16'd0;
            dwell   <= 8'd0;
            count   <= 16'd0;
        end else begin
            state   <= state_n;
            lfsr    <= {lfsr[14:0], lfsr_fb};
            Z       <= z_n;
            busy    <= busy_n;
            toggles <= toggles_n;
            target  <= target_n;
            window  <= window_n;
            dwell   <= dwell_n;
            count   <= count_n;
        end
    end

endmodule

// File: doc/bounce_emulator.md
BOUNCE_EMULATOR -- requirements
Module: bounce_emulator

Interface
REQ-001 Parameter BOUNCE_CYCLES, default 2048: length in clocks of the bounce window; legal range 4..65535.
REQ-002 Parameter HOLD_MIN, default 16: minimum clocks between two consecutive output toggles inside the window; legal range 1..255.
REQ-003 Parameter SETTLE_CYCLES, default 64: clocks the output is held stable after the window; legal range 1..65535.
REQ-004 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value; must be nonzero.
REQ-005 clock  input  1  single clock; all logic is rising-edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 P  input  1  clean switch level, synchronous to clock.
REQ-008 Z  output  1  bouncy switch contact level, registered.
REQ-009 busy  output  1  high while in BOUNCE or SETTLE, registered.
REQ-010 toggles  output  8  number of Z toggles in the current/last event, saturating.

Function
REQ-011 Three states SHALL exist: IDLE, BOUNCE and SETTLE.
REQ-012 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every clock not in reset; bit 0 is the toggle decision bit.
REQ-013 In IDLE with P != Z at a clock edge: Z toggles, target <= P, window <= 0, dwell <= 0, toggles <= 1, state -> BOUNCE; Z therefore first moves one clock after P changes.
REQ-014 In IDLE with P == Z: no output change; busy = 0.
REQ-015 In BOUNCE, window increments by 1 every clock; dwell increments by 1 every clock, except on a toggle clock, where it is cleared.
REQ-016 In BOUNCE, Z toggles when dwell >= HOLD_MIN and LFSR bit 0 = 1 and window < BOUNCE_CYCLES-1; toggles increments, saturating at 255.
REQ-017 In BOUNCE, when window == BOUNCE_CYCLES-1: Z <= target (regardless of current Z), count <= 0, state -> SETTLE.
REQ-018 In BOUNCE, if P != target: target <= P, window <= 0, no forced Z change, toggles not cleared; the event restarts toward the new level.
REQ-019 In SETTLE, Z is held at target; count increments each clock; when count == SETTLE_CYCLES-1, state -> IDLE.
REQ-020 In SETTLE, if P != target: behave as in REQ-013 (toggle Z, new target, window/dwell cleared, toggles <= 1, state -> BOUNCE).
REQ-021 busy SHALL be 1 in the cycle after entering BOUNCE through the cycle the FSM returns to IDLE, and 0 otherwise.
REQ-022 Counters window and count SHALL be 16 bits; no wrap is reachable within legal parameter ranges.
REQ-023 Invariant: once in IDLE, Z == last sampled P at the BOUNCE->SETTLE transition; Z never changes in IDLE or SETTLE except on the transitions of REQ-013/REQ-020.
REQ-024 The full event length (BOUNCE_CYCLES + SETTLE_CYCLES) SHALL be less than 4096 clocks at the defaults, so a 4096-clock sampling debouncer sees one clean transition.

Reset
REQ-025 On reset: Z = 0, busy = 0, toggles = 0, state = IDLE, LFSR = LFSR_SEED, and target, window, dwell and count = 0.
REQ-026 Reset asserted mid-BOUNCE or mid-SETTLE SHALL abort the event in that cycle; the values are those of REQ-025 on the next edge.
REQ-027 After reset deasserts with P = 1, the block SHALL treat it as a new event (REQ-013) on the first clock.

Verification (BOUNCE_CYCLES=32, HOLD_MIN=2, SETTLE_CYCLES=4)
REQ-028 Reset, P=0 for 10 clocks -> Z=0, busy=0, toggles=0 throughout.
REQ-029 P 0->1 held -> Z toggles to 1 next clock; toggles >= 1; no two Z toggles less than 2 clocks apart; Z=1 at window end; busy falls 36 clocks after entry; Z stays 1.
REQ-030 P 0->1, then back to 0 at window=10 -> window restarts; final Z=0; busy lasts 10+32+4 clocks.
REQ-031 P change during SETTLE -> immediate Z toggle, busy stays 1, toggles=1.
REQ-032 Reset asserted at window=15 -> next edge Z=0, busy=0, toggles=0, LFSR=16'hACE1.
REQ-033 Same stimulus run twice from reset -> identical Z waveforms (deterministic LFSR).
